// File: rtl/param_universal_register.sv
// WIDTH-bit universal register: hold/load/shift/rotate/mask ops plus a burst shift engine
// that performs N back-to-back shifts from a single start pulse.
module param_universal_register #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] set_m,
  input  logic [WIDTH-1:0] rst_m,
  input  logic             sin,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OpHold   = 3'b000,
    OpLoad   = 3'b001,
    OpShl    = 3'b010,
    OpShr    = 3'b011,
    OpRol    = 3'b100,
    OpRor    = 3'b101,
    OpSrMask = 3'b110,
    OpClear  = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shl_val, shr_val, rol_val, ror_val, srmask_val;

  assign shl_val = {q_q[WIDTH-2:0], sin};
  assign shr_val = {sin, q_q[WIDTH-1:1]};
  assign rol_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ror_val = {q_q[0], q_q[WIDTH-1:1]};

  // Per bit: set-only -> 1, reset-only -> 0, both -> toggle, neither -> hold.
  assign srmask_val = (q_q & ~(set_m | rst_m))
                    | (set_m & ~rst_m)
                    | (~q_q & set_m & rst_m);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cnt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StShift;
            dir_d   = dir;
            cnt_d   = (cnt > WidthCnt) ? WidthCnt : cnt;
          end
        end else begin
          unique case (op_e'(op))
            OpHold:   q_d = q_q;
            OpLoad:   q_d = d;
            OpShl: begin
              q_d   = shl_val;
              dir_d = 1'b0;
            end
            OpShr: begin
              q_d   = shr_val;
              dir_d = 1'b1;
            end
            OpRol: begin
              q_d   = rol_val;
              dir_d = 1'b0;
            end
            OpRor: begin
              q_d   = ror_val;
              dir_d = 1'b1;
            end
            OpSrMask: q_d = srmask_val;
            OpClear:  q_d = '0;
            default:  q_d = q_q;
          endcase
        end
      end

      StShift: begin
        q_d = dir_q ? shr_val : shl_val;
        if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = dir_q ? q_q[0] : q_q[WIDTH-1];
  assign busy = (state_q == StShift);
  assign done = done_q;

  // done must never overlap an active burst.
  a_done_not_busy : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: tb/tb_param_universal_register.sv
// Self-checking bench for param_universal_register: directed vector table, hand-written
// reset/back-to-back sequences, and randomized traffic against a behavioural model.
module tb_param_universal_register;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   op;
  logic [W-1:0] d, set_m, rst_m;
  logic         sin, start, dir;
  logic [3:0]   cnt;
  logic [W-1:0] q;
  logic         sout, busy, done;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: remaining shifts left in a burst, plus sout direction.
  logic [W-1:0] m_q;
  int           m_rem;
  bit           m_dir;
  bit           m_done;

  param_universal_register #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .CNT_W    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .op   (op),
    .d    (d),
    .set_m(set_m),
    .rst_m(rst_m),
    .sin  (sin),
    .start(start),
    .dir  (dir),
    .cnt  (cnt),
    .q    (q),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] sm;
    logic [W-1:0] rm;
    logic         sin;
    logic         start;
    logic         dir;
    logic [3:0]   cnt;
    logic [W-1:0] eq;
    logic         eb;
    logic         ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] o, logic [W-1:0] dd, logic [W-1:0] sm,
                              logic [W-1:0] rm, logic s, logic st, logic dr, logic [3:0] c,
                              logic [W-1:0] eq, logic eb, logic ed);
    vec_t v;
    v.op = o; v.d = dd; v.sm = sm; v.rm = rm; v.sin = s; v.start = st; v.dir = dr;
    v.cnt = c; v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  function automatic logic [W-1:0] mshift(logic [W-1:0] v, bit right, bit s);
    int x;
    int mask;
    x    = int'(v);
    mask = (1 << W) - 1;
    if (right) return W'((x >> 1) | (int'(s) << (W - 1)));
    else       return W'(((x << 1) | int'(s)) & mask);
  endfunction

  function automatic logic [W-1:0] mrot(logic [W-1:0] v, bit right);
    int x;
    int mask;
    x    = int'(v);
    mask = (1 << W) - 1;
    if (right) return W'((x >> 1) | ((x & 1) << (W - 1)));
    else       return W'(((x << 1) | (x >> (W - 1))) & mask);
  endfunction

  task automatic model_reset();
    m_q = RV; m_rem = 0; m_dir = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit nd;
    int n;
    nd = 0;
    if (m_rem > 0) begin
      m_q   = mshift(m_q, m_dir, sin);
      m_rem = m_rem - 1;
      if (m_rem == 0) nd = 1;
    end else if (start) begin
      n = (int'(cnt) > W) ? W : int'(cnt);
      if (n == 0) nd = 1;
      else begin
        m_rem = n;
        m_dir = dir;
      end
    end else begin
      case (op)
        3'b001: m_q = d;
        3'b010: begin m_q = mshift(m_q, 0, sin); m_dir = 0; end
        3'b011: begin m_q = mshift(m_q, 1, sin); m_dir = 1; end
        3'b100: begin m_q = mrot(m_q, 0); m_dir = 0; end
        3'b101: begin m_q = mrot(m_q, 1); m_dir = 1; end
        3'b110: for (int i = 0; i < W; i++) begin
          if (set_m[i] && rst_m[i]) m_q[i] = ~m_q[i];
          else if (set_m[i])        m_q[i] = 1'b1;
          else if (rst_m[i])        m_q[i] = 1'b0;
        end
        3'b111: m_q = '0;
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " q"}, q, m_q);
    chk({tag, " busy"}, W'(busy), W'(m_rem != 0));
    chk({tag, " done"}, W'(done), W'(m_done));
    chk({tag, " sout"}, W'(sout), W'(m_dir ? m_q[0] : m_q[W-1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic [2:0] o, logic [W-1:0] dd, logic [W-1:0] sm, logic [W-1:0] rm,
                       logic s, logic st, logic dr, logic [3:0] c);
    op = o; d = dd; set_m = sm; rst_m = rm; sin = s; start = st; dir = dr; cnt = c;
  endtask

  task automatic async_reset(string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, " q"}, q, RV);
    chk({tag, " busy"}, W'(busy), '0);
    chk({tag, " done"}, W'(done), '0);
    chk_model(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(3'b000, '0, '0, '0, 0, 0, 0, '0);
    #2;
    async_reset("reset");

    // op, d, set_m, rst_m, sin, start, dir, cnt, exp q, exp busy, exp done
    tbl.push_back(mk(3'b001, 8'h3C, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(3'b000, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(3'b000, 8'h55, 0, 0, 1, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(3'b001, 8'h81, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'b010, 8'h00, 0, 0, 1, 0, 0, 0, 8'h03, 0, 0));
    tbl.push_back(mk(3'b001, 8'h81, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'b100, 8'h00, 0, 0, 0, 0, 0, 0, 8'h03, 0, 0));
    tbl.push_back(mk(3'b001, 8'h81, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'b101, 8'h00, 0, 0, 1, 0, 0, 0, 8'hC0, 0, 0));
    tbl.push_back(mk(3'b001, 8'h81, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0));
    tbl.push_back(mk(3'b011, 8'h00, 0, 0, 0, 0, 0, 0, 8'h40, 0, 0));
    tbl.push_back(mk(3'b111, 8'hFF, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(3'b001, 8'hF0, 0, 0, 0, 0, 0, 0, 8'hF0, 0, 0));
    tbl.push_back(mk(3'b110, 8'h00, 8'h0F, 8'h3C, 0, 0, 0, 0, 8'hCF, 0, 0));
    // Burst left by 3; loads issued during the burst must be ignored.
    tbl.push_back(mk(3'b001, 8'hB4, 0, 0, 0, 0, 0, 0, 8'hB4, 0, 0));
    tbl.push_back(mk(3'b001, 8'hFF, 0, 0, 0, 1, 0, 3, 8'hB4, 1, 0));
    tbl.push_back(mk(3'b001, 8'hFF, 0, 0, 0, 1, 1, 7, 8'h68, 1, 0));
    tbl.push_back(mk(3'b001, 8'hFF, 0, 0, 0, 0, 0, 0, 8'hD0, 1, 0));
    tbl.push_back(mk(3'b001, 8'hFF, 0, 0, 0, 0, 0, 0, 8'hA0, 0, 1));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA0, 0, 0));
    // cnt=0: no shift, done pulse, never busy.
    tbl.push_back(mk(3'b111, 8'h00, 0, 0, 0, 1, 1, 0, 8'hA0, 0, 1));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA0, 0, 0));
    // cnt=15 saturates to 8 right shifts of ones; then back-to-back start on done.
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 1, 1, 15, 8'hA0, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hD0, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hE8, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hF4, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFA, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFD, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFE, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFF, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 1, 0, 0, 0, 8'hFF, 0, 1));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 1, 0, 2, 8'hFF, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFE, 1, 0));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFC, 0, 1));
    tbl.push_back(mk(3'b000, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFC, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].d, tbl[i].sm, tbl[i].rm, tbl[i].sin, tbl[i].start, tbl[i].dir,
            tbl[i].cnt);
      tick();
      chk($sformatf("vec%0d q", i), q, tbl[i].eq);
      chk($sformatf("vec%0d busy", i), W'(busy), W'(tbl[i].eb));
      chk($sformatf("vec%0d done", i), W'(done), W'(tbl[i].ed));
      chk_model($sformatf("vec%0d model", i));
    end

    // Reset in the 2nd cycle of a cnt=5 burst aborts it with no done pulse.
    drive(3'b000, '0, '0, '0, 1, 1, 0, 4'd5);
    tick();
    chk("abort start busy", W'(busy), W'(1'b1));
    drive(3'b000, '0, '0, '0, 1, 0, 0, '0);
    tick();
    chk("abort shift1 q", q, 8'hF9);
    #2;
    async_reset("abort reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort after q", q, RV);
      chk("abort after done", W'(done), '0);
      chk("abort after busy", W'(busy), '0);
    end
    drive(3'b000, '0, '0, '0, 0, 1, 1, 4'd2);
    tick();
    chk("restart busy", W'(busy), W'(1'b1));
    drive(3'b000, '0, '0, '0, 0, 0, 0, '0);
    tick();
    chk("restart q1", q, 8'h52);
    tick();
    chk("restart q2", q, 8'h29);
    chk("restart done", W'(done), W'(1'b1));
    chk("restart busy end", W'(busy), '0);
    chk_model("restart");

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      drive(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), W'($urandom),
            1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom), 4'($urandom_range(0, 15)));
      tick();
      chk_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 299) == 0) async_reset($sformatf("rand%0d reset", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
